// File: rtl/alu_result_buf_if.sv
// Handshake bundle between the ALU execute stage and the memory/write-back stage.
// The master drives ALU results and consumes the buffered head entry.
interface alu_result_buf_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_res;
  logic          in_zero;
  logic          in_neg;
  logic          in_ovf;
  logic [RW-1:0] in_rd;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_res;
  logic          out_zero;
  logic          out_neg;
  logic [RW-1:0] out_rd;

  modport master (
    output in_valid, in_res, in_zero, in_neg, in_ovf, in_rd, out_ready,
    input  in_ready, out_valid, out_res, out_zero, out_neg, out_rd
  );

  modport slave (
    input  in_valid, in_res, in_zero, in_neg, in_ovf, in_rd, out_ready,
    output in_ready, out_valid, out_res, out_zero, out_neg, out_rd
  );
endinterface

// File: rtl/alu_result_buf.sv
// Two-entry skid buffer for ALU results; overflowed results are dropped and
// reported through an exception pulse, a sticky flag and a saturating counter.
module alu_result_buf #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_result_buf_if.slave bus,
  input  logic          flush,
  output logic          exc_valid,
  output logic [RW-1:0] exc_rd,
  output logic          ovf_sticky,
  input  logic          ovf_clr,
  output logic [CW-1:0] ovf_count
);

  logic [DW-1:0] mem_res  [2];
  logic          mem_zero [2];
  logic          mem_neg  [2];
  logic [RW-1:0] mem_rd   [2];
  logic          head;
  logic          tail;
  logic [1:0]    count;
  logic          push;
  logic          pop;
  logic          drop;

  // in_ready depends only on the registered count, never on out_ready
  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign bus.out_res   = mem_res[head];
  assign bus.out_zero  = mem_zero[head];
  assign bus.out_neg   = mem_neg[head];
  assign bus.out_rd    = mem_rd[head];

  always_comb begin
    push = 1'b0;
    pop  = 1'b0;
    drop = 1'b0;
    if (!flush) begin
      push = bus.in_valid & bus.in_ready & ~bus.in_ovf;
      drop = bus.in_valid & bus.in_ready &  bus.in_ovf;
      pop  = bus.out_valid & bus.out_ready;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_res[i]  <= '0;
        mem_zero[i] <= 1'b0;
        mem_neg[i]  <= 1'b0;
        mem_rd[i]   <= '0;
      end
    end else if (flush) begin
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      // a push only ever writes the head slot while the buffer is empty
      if (push) begin
        mem_res[tail]  <= bus.in_res;
        mem_zero[tail] <= bus.in_zero;
        mem_neg[tail]  <= bus.in_neg;
        mem_rd[tail]   <= bus.in_rd;
        tail           <= ~tail;
      end
      if (pop) head <= ~head;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_valid  <= 1'b0;
      exc_rd     <= '0;
      ovf_sticky <= 1'b0;
      ovf_count  <= '0;
    end else begin
      exc_valid <= drop;
      if (drop) exc_rd <= bus.in_rd;
      // a drop in the same cycle as ovf_clr wins over the clear
      if (drop)         ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
      if (drop) begin
        if (ovf_clr)              ovf_count <= CW'(1);
        else if (ovf_count != '1) ovf_count <= ovf_count + CW'(1);
      end else if (ovf_clr) begin
        ovf_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_buf.sv
// Directed bench for alu_result_buf with a queue scoreboard and a reference
// model of the overflow bookkeeping, checked every cycle.
module tb_alu_result_buf;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          zero;
    logic          neg;
    logic [RW-1:0] rd;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          exc_valid;
  logic [RW-1:0] exc_rd;
  logic          ovf_sticky;
  logic          ovf_clr;
  logic [CW-1:0] ovf_count;

  alu_result_buf_if #(.DW(DW), .RW(RW)) bus ();

  alu_result_buf #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .exc_valid  (exc_valid),
    .exc_rd     (exc_rd),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
    .ovf_count  (ovf_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  entry_t      q[$];
  logic        m_exc;
  logic [RW-1:0] m_exc_rd;
  logic        m_sticky;
  int          m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(bus.in_ready), 64'(q.size() != 2));
    if (q.size() != 0) begin
      chk("out_res", 64'(bus.out_res), 64'(q[0].res));
      chk("out_zero", 64'(bus.out_zero), 64'(q[0].zero));
      chk("out_neg", 64'(bus.out_neg), 64'(q[0].neg));
      chk("out_rd", 64'(bus.out_rd), 64'(q[0].rd));
    end
    chk("exc_valid", 64'(exc_valid), 64'(m_exc));
    chk("exc_rd", 64'(exc_rd), 64'(m_exc_rd));
    chk("ovf_sticky", 64'(ovf_sticky), 64'(m_sticky));
    chk("ovf_count", 64'(ovf_count), 64'(m_cnt));
  endtask

  // One clock: predict from the driven inputs, advance, then compare.
  task automatic cycle();
    bit     acc, push, drop, pop;
    entry_t e;
    acc  = bus.in_valid && (q.size() < 2) && !flush;
    push = acc && !bus.in_ovf;
    drop = acc &&  bus.in_ovf;
    pop  = (q.size() > 0) && bus.out_ready && !flush;
    e    = '{res: bus.in_res, zero: bus.in_zero, neg: bus.in_neg, rd: bus.in_rd};
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(e);
    end
    m_exc = drop;
    if (drop) m_exc_rd = e.rd;
    if (drop)         m_sticky = 1'b1;
    else if (ovf_clr) m_sticky = 1'b0;
    if (drop)         m_cnt = ovf_clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    else if (ovf_clr) m_cnt = 0;
    check_all();
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] res, input logic [RW-1:0] rd,
                       input logic ovf, input logic z, input logic n);
    bus.in_valid = v;
    bus.in_res   = res;
    bus.in_rd    = rd;
    bus.in_ovf   = ovf;
    bus.in_zero  = z;
    bus.in_neg   = n;
  endtask

  task automatic model_reset();
    q.delete();
    m_exc    = 1'b0;
    m_exc_rd = '0;
    m_sticky = 1'b0;
    m_cnt    = 0;
  endtask

  initial begin
    int saved_cnt;
    rst_n         = 1'b0;
    flush         = 1'b0;
    ovf_clr       = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    model_reset();

    // reset values
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_res", 64'(bus.out_res), 64'd0);
    chk("rst_out_rd", 64'(bus.out_rd), 64'd0);
    chk("rst_out_zn", 64'({bus.out_zero, bus.out_neg}), 64'd0);
    chk("rst_exc", 64'({exc_valid, exc_rd}), 64'd0);
    chk("rst_ovf", 64'({ovf_sticky, ovf_count}), 64'd0);
    rst_n = 1'b1;

    // single push with one-cycle latency
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0000_0005, 5'd3, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("single_out_res", 64'(bus.out_res), 64'h5);
    chk("single_out_rd", 64'(bus.out_rd), 64'd3);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("single_drained", 64'(bus.out_valid), 64'd0);

    // backpressure and ordering
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd1, 1'b0, 1'b1, 1'b0); cycle();
    drive(1'b1, 32'hB, 5'd2, 1'b0, 1'b0, 1'b1); cycle();
    chk("bp_full", 64'(bus.in_ready), 64'd0);
    drive(1'b1, 32'hC, 5'd4, 1'b0, 1'b0, 1'b0); cycle();
    cycle();
    chk("bp_head_held", 64'(bus.out_res), 64'hA);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    cycle();
    chk("bp_second", 64'(bus.out_res), 64'hB);
    chk("bp_ready_again", 64'(bus.in_ready), 64'd1);
    cycle();
    chk("bp_empty", 64'(bus.out_valid), 64'd0);

    // full-rate streaming
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 5'(i + 8), 1'b0, 1'(i), 1'(i >> 1));
      cycle();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0); cycle();

    // overflow drop
    drive(1'b1, 32'h8000_0000, 5'd7, 1'b1, 1'b0, 1'b1);
    cycle();
    chk("ovf_exc_valid", 64'(exc_valid), 64'd1);
    chk("ovf_exc_rd", 64'(exc_rd), 64'd7);
    chk("ovf_count1", 64'(ovf_count), 64'd1);
    chk("ovf_no_out", 64'(bus.out_valid), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    cycle();
    chk("ovf_pulse_end", 64'(exc_valid), 64'd0);

    // saturation and clear
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 32'(i), 5'(i), 1'b1, 1'b0, 1'b0);
      cycle();
    end
    chk("sat_255", 64'(ovf_count), 64'd255);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    ovf_clr = 1'b1; cycle();
    chk("clr_zero", 64'({ovf_sticky, ovf_count}), 64'd0);
    drive(1'b1, 32'h1, 5'd9, 1'b1, 1'b0, 1'b0); cycle();
    chk("clr_drop_cnt", 64'(ovf_count), 64'd1);
    chk("clr_drop_sticky", 64'(ovf_sticky), 64'd1);
    ovf_clr = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0); cycle();

    // flush with two entries queued
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd11, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h22, 5'd12, 1'b0, 1'b0, 1'b0); cycle();
    saved_cnt = m_cnt;
    flush = 1'b1;
    drive(1'b1, 32'h33, 5'd13, 1'b1, 1'b0, 1'b0); cycle();
    chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
    chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
    chk("flush_no_exc", 64'(exc_valid), 64'd0);
    chk("flush_cnt_kept", 64'(ovf_count), 64'(saved_cnt));

    // flush with room available still suppresses the overflow drop
    flush = 1'b0;
    drive(1'b1, 32'h44, 5'd14, 1'b0, 1'b0, 1'b0); cycle();
    flush = 1'b1;
    drive(1'b1, 32'h55, 5'd15, 1'b1, 1'b0, 1'b0); cycle();
    chk("flush1_no_exc", 64'(exc_valid), 64'd0);
    chk("flush1_exc_rd", 64'(exc_rd), 64'd9);
    flush = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0); cycle();

    // mixed random traffic
    for (int i = 0; i < 60; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 5'($urandom), 1'($urandom_range(0, 5) == 0),
            1'($urandom), 1'($urandom));
      bus.out_ready = 1'($urandom_range(0, 2) != 0);
      cycle();
    end

    // async reset while full
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h66, 5'd16, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 32'h77, 5'd17, 1'b0, 1'b0, 1'b0); cycle();
    cycle();
    chk("pre_rst_full", 64'(bus.in_ready), 64'd0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("arst_ovf", 64'({ovf_sticky, ovf_count}), 64'd0);
    model_reset();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h99, 5'd19, 1'b0, 1'b1, 1'b1); cycle();
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0); cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
